// File: rtl/time_event_scheduler.sv
// time_event_scheduler: timed-event table scanned against the live timebase
// count. Each due event is issued on a valid/ready port in scan order. The
// block also owns the timebase clear pulse and divider configuration.
// Optional feature macro TES_LATE_FLAG_EN adds the ev_late / late_cnt outputs.
module time_event_scheduler #(
  parameter int DEPTH    = 8,
  parameter int CH_W     = 4,
  parameter int LATE_THR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            time_q,
  output logic                   tc_clr,
  output logic [15:0]            tc_nbuf,
  input  logic                   cfg_wr,
  input  logic [15:0]            cfg_nbuf,
  input  logic                   clr_req,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [31:0]            wr_time,
  input  logic [CH_W-1:0]        wr_ch,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [31:0]            ev_time,
  output logic [CH_W-1:0]        ev_ch,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef TES_LATE_FLAG_EN
  ,
  output logic                   ev_late,
  output logic [15:0]            late_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("time_event_scheduler: DEPTH must be a power of two in 2..32");
  end
  if (LATE_THR < 0) begin : g_bad_thr
    $error("time_event_scheduler: LATE_THR must be non-negative");
  end

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [31:0]       slot_time_q [DEPTH];
  logic [CH_W-1:0]   slot_ch_q [DEPTH];
  logic              ev_valid_q, ev_valid_d;
  logic [31:0]       ev_time_q, ev_time_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic [PW:0]       occ_q, occ_d;
  logic [15:0]       nbuf_q, nbuf_d;
`ifdef TES_LATE_FLAG_EN
  logic              ev_late_q, ev_late_d;
  logic [15:0]       late_cnt_q, late_cnt_d;
`endif

  logic [PW-1:0]     free_idx_s;
  logic              any_free_s;
  logic [31:0]       diff_s;
  logic              due_s;
  logic              strobe_s;
  logic              wr_acc_s;
  logic              cap_s;

  // Lowest-index free slot, judged on registered valid bits only so a slot
  // freed this cycle is reused no earlier than next cycle.
  always_comb begin
    any_free_s = 1'b0;
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = vld_q[i] ? free_idx_s : PW'(i);
      any_free_s = any_free_s | ~vld_q[i];
    end
  end

  // Wrap-safe due test: the slot is due once time_q is at or past its time
  // by less than half the counter range.
  assign diff_s   = time_q - slot_time_q[ptr_q];
  assign due_s    = vld_q[ptr_q] & ~diff_s[31];
  assign strobe_s = cfg_wr | clr_req;
  assign wr_ready = ~rst & any_free_s & (state_q != ST_FLUSH) & ~strobe_s;
  assign wr_acc_s = wr_valid & wr_ready;
  assign cap_s    = (state_q == ST_SCAN) & due_s & ~strobe_s;

  // Next-state logic: scan/fire sequencing, table bookkeeping, flush override.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    vld_d      = vld_q;
    ev_valid_d = ev_valid_q;
    ev_time_d  = ev_time_q;
    ev_ch_d    = ev_ch_q;
    nbuf_d     = nbuf_q;
    occ_d      = occ_q + (PW + 1)'(wr_acc_s) - (PW + 1)'(cap_s);
`ifdef TES_LATE_FLAG_EN
    ev_late_d  = ev_late_q;
    late_cnt_d = late_cnt_q;
`endif
    if (strobe_s) begin
      // Any strobe restarts the timebase and drops everything pending,
      // including an event waiting on the output.
      state_d    = ST_FLUSH;
      ptr_d      = '0;
      vld_d      = '0;
      ev_valid_d = 1'b0;
      occ_d      = '0;
      nbuf_d     = cfg_wr ? cfg_nbuf : nbuf_q;
`ifdef TES_LATE_FLAG_EN
      late_cnt_d = 16'd0;
`endif
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (due_s) begin
            ev_valid_d   = 1'b1;
            ev_time_d    = slot_time_q[ptr_q];
            ev_ch_d      = slot_ch_q[ptr_q];
            vld_d[ptr_q] = 1'b0;
            state_d      = ST_FIRE;
`ifdef TES_LATE_FLAG_EN
            ev_late_d    = (diff_s > 32'(LATE_THR));
`endif
          end else begin
            ptr_d = ptr_q + PW'(1);
          end
        end
        ST_FIRE: begin
          if (ev_ready) begin
            ev_valid_d = 1'b0;
            ptr_d      = ptr_q + PW'(1);
            state_d    = ST_SCAN;
`ifdef TES_LATE_FLAG_EN
            late_cnt_d = (ev_late_q && late_cnt_q != 16'hFFFF) ? late_cnt_q + 16'd1 : late_cnt_q;
`endif
          end else begin
            state_d = ST_FIRE;
          end
        end
        ST_FLUSH: begin
          state_d = ST_SCAN;
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
      vld_d[free_idx_s] = vld_d[free_idx_s] | wr_acc_s;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      ptr_q      <= '0;
      vld_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_time_q  <= 32'd0;
      ev_ch_q    <= '0;
      occ_q      <= '0;
      nbuf_q     <= 16'd0;
`ifdef TES_LATE_FLAG_EN
      ev_late_q  <= 1'b0;
      late_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vld_q      <= vld_d;
      ev_valid_q <= ev_valid_d;
      ev_time_q  <= ev_time_d;
      ev_ch_q    <= ev_ch_d;
      occ_q      <= occ_d;
      nbuf_q     <= nbuf_d;
`ifdef TES_LATE_FLAG_EN
      ev_late_q  <= ev_late_d;
      late_cnt_q <= late_cnt_d;
`endif
    end
  end

  // Slot payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      slot_time_q[free_idx_s] <= wr_time;
      slot_ch_q[free_idx_s]   <= wr_ch;
    end
  end

  assign tc_clr    = rst | (state_q == ST_FLUSH);
  assign tc_nbuf   = nbuf_q;
  assign ev_valid  = ev_valid_q;
  assign ev_time   = ev_time_q;
  assign ev_ch     = ev_ch_q;
  assign occupancy = occ_q;
`ifdef TES_LATE_FLAG_EN
  assign ev_late   = ev_late_q;
  assign late_cnt  = late_cnt_q;
`endif

endmodule

// File: tb/tb_time_event_scheduler.sv
// Scoreboard bench for time_event_scheduler: stimulus pushes expected events,
// a monitor pops and compares on every output handshake.
module tb_time_event_scheduler;
  localparam int DEPTH = 8;
  localparam int CH_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] time_q;
  logic tc_clr;
  logic [15:0] tc_nbuf;
  logic cfg_wr;
  logic [15:0] cfg_nbuf;
  logic clr_req;
  logic wr_valid;
  logic wr_ready;
  logic [31:0] wr_time;
  logic [CH_W-1:0] wr_ch;
  logic ev_valid;
  logic ev_ready;
  logic [31:0] ev_time;
  logic [CH_W-1:0] ev_ch;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef TES_LATE_FLAG_EN
  logic ev_late;
  logic [15:0] late_cnt;
`endif

  always #5 clk = ~clk;

  time_event_scheduler #(.DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .time_q(time_q), .tc_clr(tc_clr), .tc_nbuf(tc_nbuf),
    .cfg_wr(cfg_wr), .cfg_nbuf(cfg_nbuf), .clr_req(clr_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_time(wr_time), .wr_ch(wr_ch),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time), .ev_ch(ev_ch),
    .occupancy(occupancy)
`ifdef TES_LATE_FLAG_EN
    , .ev_late(ev_late), .late_cnt(late_cnt)
`endif
  );

  typedef struct {
    logic [31:0]     t;
    logic [CH_W-1:0] ch;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_chk = 0;
  int  n_err = 0;
  int  n_push = 0;
  int  deliv_cnt = 0;
  int  rdy_mode = 0;   // 0: hold low, 1: always high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] t, input logic [CH_W-1:0] c);
    ev_t e;
    e.t = t;
    e.ch = c;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Drive one write and hold it until the table takes it.
  task automatic do_write(input logic [31:0] t, input logic [CH_W-1:0] c);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    wr_valid = 1'b1;
    wr_time = t;
    wr_ch = c;
    while (!acc && guard < 400) begin
      smp();
      acc = wr_ready;
      step();
      guard++;
    end
    wr_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL write_timeout: write of time %0h not accepted within 400 cycles", t);
    end
  endtask

  // Wait until every pushed expectation has been delivered, bounded.
  task automatic wait_deliv(input string name, input int budget);
    int n;
    n = 0;
    while (deliv_cnt < n_push && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(deliv_cnt), 32'(n_push));
  endtask

  // Consumer ready generator.
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: a handshake seen at the falling edge completes at the next rise.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_event: got time %0h ch %0h, required no event", ev_time, ev_ch);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_time", ev_time, mon_e.t);
        chk("ev_ch", 32'(ev_ch), 32'(mon_e.ch));
      end
      deliv_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit acc;
    bit seen;
    int guard;
    int n;
    int j;
    int tmp;
    logic [31:0] base;
    logic [31:0] tt [DEPTH];
    logic [CH_W-1:0] cc [DEPTH];
    int perm [DEPTH];

    rst = 1'b1; time_q = 32'd0; cfg_wr = 1'b0; cfg_nbuf = 16'd0; clr_req = 1'b0;
    wr_valid = 1'b0; wr_time = 32'd0; wr_ch = '0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_tc_clr", 32'(tc_clr), 32'd1);
    chk("rst_tc_nbuf", 32'(tc_nbuf), 32'd0);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_time", ev_time, 32'd0);
    chk("rst_ev_ch", 32'(ev_ch), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    step();
    rst = 1'b0;
    smp();
    chk("idle_tc_clr", 32'(tc_clr), 32'd0);
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    step();

    // Single event at time 100, latency bounded by one full scan.
    rdy_mode = 1;
    do_write(32'd100, 4'd3);
    smp();
    chk("t1_occupancy", 32'(occupancy), 32'd1);
    step();
    push(32'd100, 4'd3);
    time_q = 32'd100;
    lat = 0;
    while (!ev_valid && lat < 4 * DEPTH) begin
      smp();
      lat++;
    end
    chk("t1_latency", 32'(lat <= DEPTH + 1), 32'd1);
    step();
    wait_deliv("t1_deliver", 50);
    smp();
    chk("t1_occ_empty", 32'(occupancy), 32'd0);
    step();

    // Fill the table, stall a ninth write, release it as the first slot fires.
    time_q = 32'd0;
    for (int i = 0; i < DEPTH; i++) do_write(32'(10 * (i + 1)), CH_W'(i));
    smp();
    chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
    step();
    wr_valid = 1'b1; wr_time = 32'd90; wr_ch = 4'd9;
    repeat (3) begin
      smp();
      chk("full_stall", 32'(wr_ready), 32'd0);
      step();
    end
    push(32'd10, 4'd0);
    time_q = 32'd10;
    acc = 1'b0; seen = 1'b0; guard = 0;
    while (!acc && guard < 40) begin
      smp();
      if (ev_valid && !seen) begin
        seen = 1'b1;
        chk("stall_release", 32'(wr_ready), 32'd1);
      end
      acc = wr_ready;
      step();
      guard++;
    end
    wr_valid = 1'b0;
    chk("stall_accepted", 32'(acc), 32'd1);
    wait_deliv("fill_first", 50);
    for (int k = 2; k <= 9; k++) begin
      push(32'(10 * k), (k <= 8) ? CH_W'(k - 1) : CH_W'(9));
      time_q = 32'(10 * k);
      wait_deliv("fill_order", 50);
    end

    // Three events due together under back-pressure; scan starts at slot 0.
    rdy_mode = 0;
    time_q = 32'd50;
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    do_write(32'd50, 4'd1);
    do_write(32'd50, 4'd2);
    do_write(32'd50, 4'd3);
    repeat (10) step();
    smp();
    chk("bp_valid_a", 32'(ev_valid), 32'd1);
    chk("bp_ch_a", 32'(ev_ch), 32'd1);
    repeat (10) step();
    smp();
    chk("bp_valid_b", 32'(ev_valid), 32'd1);
    chk("bp_time_b", ev_time, 32'd50);
    chk("bp_ch_b", 32'(ev_ch), 32'd1);
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    step();
    push(32'd50, 4'd1);
    push(32'd50, 4'd2);
    push(32'd50, 4'd3);
    rdy_mode = 1;
    wait_deliv("bp_deliver", 60);
    repeat (5) step();
    smp();
    chk("bp_drained_valid", 32'(ev_valid), 32'd0);
    chk("bp_drained_occ", 32'(occupancy), 32'd0);
    step();

    // Wrap-around of the timebase, then an already-late event.
    time_q = 32'hFFFF_FFF0;
    do_write(32'h0000_0005, 4'd4);
    repeat (20) step();
    time_q = 32'h0000_0004;
    repeat (15) step();
    smp();
    chk("wrap_nofire", 32'(ev_valid), 32'd0);
    chk("wrap_nodeliv", 32'(deliv_cnt), 32'(n_push));
    step();
    push(32'h0000_0005, 4'd4);
    time_q = 32'h0000_0005;
    wait_deliv("wrap_fire", 40);
    push(32'hFFFF_FFE0, 4'd5);
    do_write(32'hFFFF_FFE0, 4'd5);
    wait_deliv("late_fire", 40);

    // Configuration write while an event is held and four slots are pending.
    rdy_mode = 0;
    time_q = 32'd200;
    for (int i = 0; i < 5; i++) do_write(32'(100 + i), CH_W'(i));
    repeat (12) step();
    smp();
    chk("cfg_pre_valid", 32'(ev_valid), 32'd1);
    chk("cfg_pre_occ", 32'(occupancy), 32'd4);
    step();
    cfg_wr = 1'b1; cfg_nbuf = 16'h0040;
    wr_valid = 1'b1; wr_time = 32'd300; wr_ch = 4'd7;
    smp();
    chk("cfg_wr_blocks_write", 32'(wr_ready), 32'd0);
    step();
    cfg_wr = 1'b0; wr_valid = 1'b0;
    smp();
    chk("cfg_tc_clr", 32'(tc_clr), 32'd1);
    chk("cfg_tc_nbuf", 32'(tc_nbuf), 32'h40);
    chk("cfg_ev_dropped", 32'(ev_valid), 32'd0);
    chk("cfg_occ", 32'(occupancy), 32'd0);
    step();
    smp();
    chk("cfg_tc_clr_end", 32'(tc_clr), 32'd0);
    step();
    rdy_mode = 1;
    repeat (20) step();
    smp();
    chk("cfg_occ_after", 32'(occupancy), 32'd0);
    step();

    // Two-cycle clear strobe extends the flush; divider is kept.
    clr_req = 1'b1;
    step();
    smp();
    chk("clr_tc_clr_1", 32'(tc_clr), 32'd1);
    step();
    clr_req = 1'b0;
    smp();
    chk("clr_tc_clr_2", 32'(tc_clr), 32'd1);
    step();
    smp();
    chk("clr_tc_clr_end", 32'(tc_clr), 32'd0);
    chk("clr_keeps_nbuf", 32'(tc_nbuf), 32'h40);
    step();

    // Randomized batches: distinct increasing times written in shuffled
    // order; stepping the timebase through them must yield time order.
    rdy_mode = 2;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, DEPTH);
      base = $urandom;
      time_q = base - 32'd1;
      for (int k = 0; k < n; k++) begin
        tt[k] = base + 32'(k * 64) + 32'($urandom_range(0, 20));
        cc[k] = CH_W'($urandom_range(0, (1 << CH_W) - 1));
        perm[k] = k;
      end
      for (int k = n - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = perm[k];
        perm[k] = perm[j];
        perm[j] = tmp;
      end
      for (int k = 0; k < n; k++) do_write(tt[perm[k]], cc[perm[k]]);
      smp();
      chk("rnd_occupancy", 32'(occupancy), 32'(n));
      step();
      for (int k = 0; k < n; k++) begin
        push(tt[k], cc[k]);
        time_q = tt[k] + 32'($urandom_range(0, 3));
        wait_deliv("rnd_deliver", 200);
      end
      smp();
      chk("rnd_occ_empty", 32'(occupancy), 32'd0);
      step();
    end

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
